instruction_fetch: RTL and testbench

Upstream neighbour of the decode stage in the lab CPU. Generates the word PC, issues single-outstanding requests to instruction memory, and buffers returned 32-bit instructions in a small FIFO. Presents them to decode as `Instruction`/`InstrPC` with a valid/stall handshake. Supports PC redirect with flush of in-flight fetches, and a halt opcode that stops fetching.

---
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: word PC, single-outstanding imem requests, DEPTH-entry {pc, word} FIFO to decode.
// Two cycles min from request to decode; Stall holds the head and fetch pauses when the FIFO has no room.
module instruction_fetch #(
  parameter int         ADDR_W  = 8,
  parameter int         DEPTH   = 4,
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemValid,
  input  logic [31:0]       ImemData,
  output logic [31:0]       Instruction,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              InstrValid,
  output logic              Halted
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} fetchState_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       word;
  } fifoEntry_t;

  fetchState_t       state, stateNext;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count, countNext;
  logic [PTR_W-1:0]  rdPtr, wrPtr;
  fifoEntry_t        fifoMem [DEPTH];
  logic              push, pop, issue, hasSpace;

  // ImemAddr holds the outstanding request's PC until the next issue, so it tags the response.
  always_comb begin
    pop       = (count != '0) && !Stall && !Redirect;
    push      = ImemValid && (state == WAIT) && !Redirect;
    countNext = count + CNT_W'(push) - CNT_W'(pop);
    hasSpace  = countNext < FULL;
    issue     = 1'b0;
    stateNext = state;
    if (Redirect) begin
      case (state)
        WAIT:    stateNext = ImemValid ? IDLE : DROP;
        DROP:    stateNext = ImemValid ? IDLE : DROP;
        default: stateNext = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (hasSpace) begin
            issue     = 1'b1;
            stateNext = WAIT;
          end
        end
        WAIT: begin
          if (ImemValid) begin
            if (ImemData[31:24] == HALT_OP) stateNext = HALT;
            else if (hasSpace)              issue     = 1'b1;
            else                            stateNext = IDLE;
          end
        end
        DROP: begin
          if (ImemValid) stateNext = IDLE;
        end
        HALT:    stateNext = HALT;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      pc       <= '0;
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      ImemReq  <= 1'b0;
      ImemAddr <= '0;
    end else begin
      state   <= stateNext;
      ImemReq <= issue;
      if (issue) ImemAddr <= pc;
      if (Redirect)   pc <= RedirectPC;
      else if (issue) pc <= pc + ADDR_W'(1);
      if (Redirect) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        count <= countNext;
        if (push) wrPtr <= wrPtr + PTR_W'(1);
        if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (push) fifoMem[wrPtr] <= {ImemAddr, ImemData};
  end

  assign InstrValid  = (count != '0);
  assign Instruction = InstrValid ? fifoMem[rdPtr].word : 32'h0;
  assign InstrPC     = InstrValid ? fifoMem[rdPtr].pc : '0;
  assign Halted      = (state == HALT);
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural imem with programmable latency, request and
// delivery scoreboards fed by directed scenarios, plus cycle-exact point checks.
module tb_instruction_fetch;
  logic        Clk, Reset, Stall, Redirect;
  logic [7:0]  RedirectPC;
  logic        ImemReq;
  logic [7:0]  ImemAddr;
  logic        ImemValid;
  logic [31:0] ImemData;
  logic [31:0] Instruction;
  logic [7:0]  InstrPC;
  logic        InstrValid, Halted;

  int checks = 0;
  int errors = 0;
  int reqCount = 0;
  bit monEn = 0;
  int memLat = 1;
  int haltAddr = -1;
  logic [7:0]  expReq[$];
  logic [39:0] expDel[$];

  instruction_fetch #(.ADDR_W(8), .DEPTH(4), .HALT_OP(8'hFF)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemValid(ImemValid), .ImemData(ImemData),
    .Instruction(Instruction), .InstrPC(InstrPC), .InstrValid(InstrValid), .Halted(Halted)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memWord(input logic [7:0] a);
    if (int'(a) == haltAddr) return 32'hFF00_0000;
    return 32'h0100_0000 + {24'h0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory: a request seen in cycle N answers in cycle N+memLat.
  initial begin
    int  cyc = 0;
    int  due = 0;
    bit  pending = 0;
    logic [7:0] pendAddr = 8'h0;
    ImemValid = 1'b0;
    ImemData  = 32'h0;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      ImemValid = 1'b0;
      ImemData  = 32'h0;
      if (!Reset) begin
        pending = 0;
      end else begin
        if (pending && cyc == due) begin
          ImemValid = 1'b1;
          ImemData  = memWord(pendAddr);
          pending   = 0;
        end
        if (ImemReq) begin
          pending  = 1;
          pendAddr = ImemAddr;
          due      = cyc + memLat;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (Reset) begin
      if (ImemReq) begin
        reqCount++;
        if (monEn && expReq.size() > 0) check("req_addr", ImemAddr, expReq.pop_front());
      end
      if (monEn && InstrValid && !Stall && !Redirect && expDel.size() > 0)
        check("deliver", {InstrPC, Instruction}, expDel.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic checkResetOuts(input string p);
    check({p, "_imemreq"}, ImemReq, 0);
    check({p, "_imemaddr"}, ImemAddr, 0);
    check({p, "_instrvalid"}, InstrValid, 0);
    check({p, "_instruction"}, Instruction, 0);
    check({p, "_instrpc"}, InstrPC, 0);
    check({p, "_halted"}, Halted, 0);
  endtask

  // Leaves the bench in cycle C0, with Reset released at its start.
  task automatic doReset(input int lat, input int halt, input logic stallVal);
    monEn      = 0;
    Reset      = 1'b0;
    Stall      = stallVal;
    Redirect   = 1'b0;
    RedirectPC = 8'h0;
    expReq.delete();
    expDel.delete();
    memLat   = lat;
    haltAddr = halt;
    tick(3);
    checkResetOuts("rst");
    reqCount = 0;
    monEn    = 1;
    Reset    = 1'b1;
  endtask

  task automatic endTest(input string name);
    check({name, "_req_drain"}, expReq.size(), 0);
    check({name, "_del_drain"}, expDel.size(), 0);
  endtask

  task automatic waitReq(input logic [7:0] a, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick(1);
      if (ImemReq && ImemAddr == a) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_req: no request for 0x%0h within %0d cycles", a, budget);
    end
  endtask

  initial begin
    Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 8'h0;

    // Streaming with 1-cycle memory
    doReset(1, -1, 1'b0);
    for (int i = 0; i <= 8; i++) expReq.push_back(8'(i));
    for (int i = 0; i <= 7; i++) expDel.push_back({8'(i), 32'h0100_0000 + 32'(i)});
    tick(1);
    check("t1_first_req", ImemReq, 1);
    check("t1_first_addr", ImemAddr, 0);
    check("t1_c1_valid", InstrValid, 0);
    tick(1);
    check("t1_c2_req", ImemReq, 0);
    check("t1_c2_valid", InstrValid, 0);
    tick(1);
    check("t1_c3_valid", InstrValid, 1);
    check("t1_c3_pc", InstrPC, 0);
    tick(15);
    endTest("t1");

    // Stall fills the FIFO, then drain one per cycle
    doReset(1, -1, 1'b1);
    for (int i = 0; i <= 4; i++) expReq.push_back(8'(i));
    for (int i = 0; i <= 4; i++) expDel.push_back({8'(i), 32'h0100_0000 + 32'(i)});
    tick(20);
    check("t2_reqcount", reqCount, 4);
    check("t2_req_idle", ImemReq, 0);
    check("t2_full_valid", InstrValid, 1);
    check("t2_head0", InstrPC, 0);
    Stall = 1'b0;
    tick(1);
    check("t2_head1", InstrPC, 1);
    check("t2_resume_req", ImemReq, 1);
    check("t2_resume_addr", ImemAddr, 4);
    tick(1);
    check("t2_head2", InstrPC, 2);
    tick(1);
    check("t2_head3", InstrPC, 3);
    tick(6);
    endTest("t2");

    // Redirect while a 3-cycle fetch is outstanding
    doReset(3, -1, 1'b0);
    for (int i = 0; i <= 5; i++) expReq.push_back(8'(i));
    expReq.push_back(8'h40); expReq.push_back(8'h41);
    for (int i = 0; i <= 4; i++) expDel.push_back({8'(i), 32'h0100_0000 + 32'(i)});
    expDel.push_back({8'h40, 32'h0100_0040}); expDel.push_back({8'h41, 32'h0100_0041});
    waitReq(8'h05, 40);
    tick(1);
    Redirect = 1'b1; RedirectPC = 8'h40;
    tick(1);
    Redirect = 1'b0;
    check("t3_flushed", InstrValid, 0);
    tick(2);
    check("t3_drop_noreq", ImemReq, 0);
    tick(1);
    check("t3_redir_req", ImemReq, 1);
    check("t3_redir_addr", ImemAddr, 8'h40);
    tick(10);
    endTest("t3");

    // Redirect coincident with ImemValid while stalled
    doReset(1, -1, 1'b1);
    expReq.push_back(8'h00); expReq.push_back(8'h20);
    tick(2);
    Redirect = 1'b1; RedirectPC = 8'h20;
    tick(1);
    Redirect = 1'b0;
    check("t4_dropped_valid", InstrValid, 0);
    check("t4_c3_req", ImemReq, 0);
    tick(1);
    check("t4_req", ImemReq, 1);
    check("t4_addr", ImemAddr, 8'h20);
    tick(2);
    check("t4_valid", InstrValid, 1);
    check("t4_pc", InstrPC, 8'h20);
    check("t4_word", Instruction, 32'h0100_0020);
    endTest("t4");

    // Halt opcode at address 3
    doReset(1, 3, 1'b0);
    for (int i = 0; i <= 3; i++) expReq.push_back(8'(i));
    expReq.push_back(8'h00);
    for (int i = 0; i <= 2; i++) expDel.push_back({8'(i), 32'h0100_0000 + 32'(i)});
    expDel.push_back({8'h03, 32'hFF00_0000});
    expDel.push_back({8'h00, 32'h0100_0000});
    tick(8);
    check("t5_not_yet_halted", Halted, 0);
    tick(1);
    check("t5_halted", Halted, 1);
    check("t5_halt_pc", InstrPC, 3);
    check("t5_halt_word", Instruction, 32'hFF00_0000);
    reqCount = 0;
    tick(50);
    check("t5_no_reqs", reqCount, 0);
    check("t5_still_halted", Halted, 1);
    check("t5_drained", InstrValid, 0);
    Redirect = 1'b1; RedirectPC = 8'h00;
    tick(1);
    Redirect = 1'b0;
    check("t5_unhalted", Halted, 0);
    check("t5_h1_req", ImemReq, 0);
    tick(1);
    check("t5_restart_req", ImemReq, 1);
    check("t5_restart_addr", ImemAddr, 0);
    tick(4);
    endTest("t5");

    // PC wrap from 0xFF to 0x00
    doReset(1, -1, 1'b0);
    expReq.push_back(8'h00); expReq.push_back(8'hFF); expReq.push_back(8'h00);
    expDel.push_back({8'hFF, 32'h0100_00FF}); expDel.push_back({8'h00, 32'h0100_0000});
    tick(2);
    Redirect = 1'b1; RedirectPC = 8'hFF;
    tick(1);
    Redirect = 1'b0;
    check("t6_flushed", InstrValid, 0);
    tick(1);
    check("t6_req_ff", ImemReq, 1);
    check("t6_addr_ff", ImemAddr, 8'hFF);
    tick(2);
    check("t6_req_wrap", ImemReq, 1);
    check("t6_addr_wrap", ImemAddr, 8'h00);
    check("t6_head_ff", InstrPC, 8'hFF);
    tick(3);
    endTest("t6");

    // Asynchronous reset while waiting with three entries buffered
    doReset(3, -1, 1'b1);
    waitReq(8'h03, 40);
    check("t7_pre_valid", InstrValid, 1);
    check("t7_pre_req", ImemReq, 1);
    #3;
    Reset = 1'b0;
    #1;
    checkResetOuts("async");
    monEn = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
